led_pattern_master: RTL

Avalon-MM master that drives LED patterns into the system's 8-bit LED PIO slave port (`s1`) and sits directly upstream of it. Every STEP_CYCLES clocks it computes the next pattern for the selected mode and writes it to the PIO data register. It then reads the register back and flags any mismatch. It is the only master on that port; the PIO's external export drives the board LEDs.

---
 rtl/led_pattern_pkg.sv | 80 ++++++++
 rtl/led_pattern_master_if.sv | 20 ++
 rtl/led_step_timer.sv | 35 +++
 rtl/led_pattern_master.sv | 104 ++++++++++
 4 files changed

// File: rtl/led_pattern_pkg.sv
// Shared types, mode/seed constants and next-pattern rule for the LED pattern master.
// Latency: pure definitions; next_pattern is combinational.
// Backpressure: none.
package led_pattern_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_WRITE,
    ST_READ,
    ST_CHECK
  } state_e;

  typedef enum logic {
    DIR_UP,
    DIR_DOWN
  } dir_e;

  localparam logic [1:0] MODE_WALK   = 2'd0;
  localparam logic [1:0] MODE_COUNT  = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_BLINK  = 2'd3;

  localparam logic [7:0] SEED_WALK   = 8'h01;
  localparam logic [7:0] SEED_COUNT  = 8'h00;
  localparam logic [7:0] SEED_BOUNCE = 8'h01;
  localparam logic [7:0] SEED_BLINK  = 8'hFF;

  typedef struct packed {
    dir_e       dir;
    logic [7:0] pat;
  } step_t;

  // First pattern shown after switching into a mode.
  function automatic logic [7:0] seed_of(input logic [1:0] mode);
    case (mode)
      MODE_WALK:   seed_of = SEED_WALK;
      MODE_COUNT:  seed_of = SEED_COUNT;
      MODE_BOUNCE: seed_of = SEED_BOUNCE;
      default:     seed_of = SEED_BLINK;
    endcase
  endfunction

  // Derives the following pattern from the current one; direction only matters for bounce.
  function automatic step_t next_pattern(input logic [1:0] mode, input logic [7:0] cur,
                                         input dir_e dir);
    step_t r;
    r.dir = DIR_UP;
    r.pat = cur;
    case (mode)
      MODE_WALK:  r.pat = (cur == 8'h00) ? SEED_WALK : {cur[6:0], cur[7]};
      MODE_COUNT: r.pat = cur + 8'd1;
      MODE_BOUNCE: begin
        if (cur == 8'h00 || (cur & (cur - 8'd1)) != 8'h00) begin
          r.pat = SEED_BOUNCE;
          r.dir = DIR_UP;
        end else if (dir == DIR_UP) begin
          if (cur[7]) begin
            r.pat = 8'h40;
            r.dir = DIR_DOWN;
          end else begin
            r.pat = cur << 1;
            r.dir = DIR_UP;
          end
        end else begin
          if (cur[0]) begin
            r.pat = 8'h02;
            r.dir = DIR_UP;
          end else begin
            r.pat = cur >> 1;
            r.dir = DIR_DOWN;
          end
        end
      end
      default: r.pat = (cur == 8'hFF) ? 8'h00 : 8'hFF;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/led_pattern_master_if.sv
// Avalon-MM link between the pattern master and the 8-bit LED PIO slave.
// Latency: wires only.
// Backpressure: none; the PIO has fixed read latency of one cycle and no waitrequest.
interface led_pattern_master_if;
  logic [1:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address, avm_chipselect, avm_write_n, avm_writedata,
    input  avm_readdata
  );

  modport slave (
    input  avm_address, avm_chipselect, avm_write_n, avm_writedata,
    output avm_readdata
  );
endinterface

// File: rtl/led_step_timer.sv
// Free-running terminal counter that pulses tick once every STEP_CYCLES clocks while run is high.
// Latency: tick is combinational from the count register, high on count STEP_CYCLES-1.
// Backpressure: none; clear forces the count to 0 and suppresses tick.
module led_step_timer #(
  parameter int unsigned STEP_CYCLES = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam logic [31:0] TERM = STEP_CYCLES - 1;

  if (STEP_CYCLES < 4) begin : g_bad_step
    $error("led_step_timer: STEP_CYCLES must be at least 4");
  end

  logic [31:0] cnt;

  // Count 0..TERM and wrap; held at 0 while cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= (cnt == TERM) ? '0 : cnt + 32'd1;
    end
  end

  assign tick = run && !clear && (cnt == TERM);

endmodule

// File: rtl/led_pattern_master.sv
// Periodically writes the next LED pattern to the PIO data register and verifies it by readback.
// Latency: first write STEP_CYCLES+1 clocks after enable; then one write every STEP_CYCLES clocks.
// Backpressure: none on the bus; enable low finishes any write/read/check in flight, then idles.
module led_pattern_master
  import led_pattern_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = 5_000_000
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset,
  input  logic                 enable,
  input  logic [1:0]           mode,
  led_pattern_master_if.master avm,
  output logic [7:0]           pattern,
  output logic                 busy,
  output logic                 mismatch
);

  state_e     state;
  dir_e       dir;
  logic [1:0] mode_q;
  logic       tick;
  logic       timer_clear;
  step_t      step_nxt;
  logic       unused_rd_hi;

  // Timer sits at 0 in IDLE and is zeroed on the way into IDLE so WAIT always starts at 0.
  always_comb begin
    timer_clear = (state == ST_IDLE) ||
                  (!enable && (state == ST_WAIT || state == ST_CHECK));
  end

  // A mode change restarts from that mode's seed instead of deriving from the old pattern.
  always_comb begin
    step_nxt = next_pattern(mode, pattern, dir);
    if (mode != mode_q) begin
      step_nxt.pat = seed_of(mode);
      step_nxt.dir = DIR_UP;
    end
  end

  led_step_timer #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_timer (
    .clk  (clk_clk),
    .rst  (reset_reset),
    .run  (!timer_clear),
    .clear(timer_clear),
    .tick (tick)
  );

  assign avm.avm_address = 2'b00;
  assign unused_rd_hi    = ^avm.avm_readdata[31:8];

  // Sequencer: wait for tick, write, read back, compare; all bus outputs registered here.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state              <= ST_IDLE;
      dir                <= DIR_UP;
      mode_q             <= MODE_WALK;
      pattern            <= 8'h00;
      busy               <= 1'b0;
      mismatch           <= 1'b0;
      avm.avm_chipselect <= 1'b0;
      avm.avm_write_n    <= 1'b1;
      avm.avm_writedata  <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (!enable) begin
            state <= ST_IDLE;
          end else if (tick) begin
            state              <= ST_WRITE;
            dir                <= step_nxt.dir;
            mode_q             <= mode;
            busy               <= 1'b1;
            avm.avm_chipselect <= 1'b1;
            avm.avm_write_n    <= 1'b0;
            avm.avm_writedata  <= {24'h0, step_nxt.pat};
          end
        end
        ST_WRITE: begin
          state           <= ST_READ;
          pattern         <= avm.avm_writedata[7:0];
          avm.avm_write_n <= 1'b1;
        end
        ST_READ: begin
          state              <= ST_CHECK;
          avm.avm_chipselect <= 1'b0;
        end
        ST_CHECK: begin
          if (avm.avm_readdata[7:0] != pattern) mismatch <= 1'b1;
          busy  <= 1'b0;
          state <= enable ? ST_WAIT : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
